full_argmax: RTL and testbench
==============================

// Module: full_argmax
// PURPOSE
//  Output classifier behind the fully-connected network. It consumes the final-stage
//  float_24_8 result stream, one frame of NUM_CLASSES beats with fst on beat 0.
//  It finds the index of the maximum value, compares that index with a label from a
//  separate label stream, and emits one classification record per frame over vld/rdy.
// PARAMETERS
//  NUM_CLASSES  6   beats per frame (output-layer width); range 2..255
//  IDX_W        8   width of class index, label and beat counter
// PORTS
//  clk           in   1      system clock
//  reset         in   1      synchronous, active-high reset
//  st_data_out       in   32  final-stage result value (float_24_8)
//  st_data_out_vld   in   1   result beat valid
//  st_data_out_fst   in   1   first beat of frame
//  st_data_out_rdy   out  1   block accepts result beat
//  label         in   IDX_W  expected class for the current frame
//  label_vld     in   1      label valid
//  label_rdy     out  1      block accepts label
//  class_out     out  IDX_W  argmax index
//  class_max     out  32     value at argmax (float_24_8)
//  class_ok      out  1      class_out == latched label
//  class_vld     out  1      record valid
//  class_rdy     in   1      downstream accepts record
//  frame_abort   out  1      1-cycle pulse: partial frame discarded by early fst
// BEHAVIOUR
//  - Clock and reset: one clock (clk). reset is synchronous and active-high.
//  - Reset values: st_data_out_rdy=1, label_rdy=1, class_vld=0, class_ok=0,
//    class_out=0, class_max=0, frame_abort=0. FSM returns to IDLE.
//  - Reset mid-operation: the partial frame, the held label and any pending record are discarded.
//  - Beat accept = st_data_out_vld & st_data_out_rdy.
//  - Label accept = label_vld & label_rdy. label_rdy = !label_held.
//    label_held clears when a record handshakes.
//  - FSM states: IDLE, ACCUM, RESULT.
//   IDLE: a non-fst beat is accepted and dropped.
//     A fst beat loads best_val/best_idx=0, sets beat_cnt=1 and moves to ACCUM.
//   ACCUM: each beat at index beat_cnt replaces the best only if strictly greater.
//     Ties keep the lowest index.
//     A fst beat in ACCUM restarts the frame as in IDLE and pulses frame_abort the next cycle.
//     On the beat where beat_cnt==NUM_CLASSES-1, the frame completes and the FSM moves to RESULT.
//   RESULT: st_data_out_rdy=0.
//     class_vld=1 once label_held (possibly the same cycle as entry).
//     Outputs are held stable while class_vld & !class_rdy.
//     On handshake: go to IDLE, drop label_held, st_data_out_rdy=1 the next cycle.
//  - Latency: class_vld rises 1 cycle after the last beat is accepted, if the label is already held.
//    Otherwise it rises 1 cycle after the label is accepted.
//  - Compare: float_24_8 = {sign[31], exp[30:23], mant[22:0]}.
//    Ordered key: sign ? ~v : v^32'h8000_0000, compared as unsigned 32-bit.
//    -0 and +0 are forced equal (magnitude 0 maps to key 32'h8000_0000).
//  - NUM_CLASSES==1 is illegal; elaboration fatal.
// CONFIGURATION
//  FULL_ARGMAX_STATS_EN defined:
//   - adds ports frames_total (out, 32) and frames_ok (out, 32).
//   - Both counters are reset to 0 and increment on each record handshake.
//   - frames_ok increments only when class_ok=1. Both wrap at 2^32.
//  FULL_ARGMAX_STATS_EN undefined: neither port nor counter exists; all other behaviour is identical.
// STRUCTURE
//  - Shared package: float_24_8 typedef, full_argmax_state_t enum, and the
//    function f24_8_key() (float-to-ordered-key conversion).
//  - Sub-module: f24_8_gt (combinational a>b using the keys).
//    It is reused later by the pooling and softmax stages.
// TESTING
//  1. Frame of values {1.0,3.0,2.0,-4.0,0.5,0.0}, label 1
//     -> class_out=1, class_max=32'h40400000, class_ok=1.
//  2. Tie {2.0,5.0,5.0,...}, label 2 -> class_out=1, class_ok=0.
//  3. Label held off 10 cycles after the frame
//     -> st_data_out_rdy=0 throughout; class_vld rises 1 cycle after label accept.
//  4. fst on beat 3, then a full 6-beat frame
//     -> one frame_abort pulse; one record, for the second frame only.
//  5. class_rdy=0 for 5 cycles -> record is stable; no beats are accepted; the next
//     frame starts cleanly. Then apply reset during ACCUM -> all outputs are at reset values
//     the next cycle.
//  6. STATS_EN: 8 frames with 5 correct -> frames_total=8, frames_ok=5.
//     Values -0.0 vs +0.0 -> index 0 wins.

Source files
------------

// File: rtl/full_argmax_pkg.sv
// Shared float_24_8 types, argmax FSM states and the float-to-ordered-key helper.
package full_argmax_pkg;

  localparam int unsigned FLOAT_W = 32;

  typedef logic [FLOAT_W-1:0] float_24_8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    RESULT = 2'd2
  } full_argmax_state_t;

  // Map a float onto an unsigned key with the same ordering; both zeros share one key.
  function automatic logic [FLOAT_W-1:0] f24_8_key(input float_24_8 v);
    logic [FLOAT_W-1:0] key;
    if (v[FLOAT_W-2:0] == '0) begin
      key = 32'h8000_0000;
    end else if (v[FLOAT_W-1]) begin
      key = ~v;
    end else begin
      key = v ^ 32'h8000_0000;
    end
    return key;
  endfunction

endpackage

// File: rtl/f24_8_gt.sv
// Combinational float_24_8 strict greater-than; shared with pooling and softmax stages.
module f24_8_gt
  import full_argmax_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        a_gt_b_c
);

  assign a_gt_b_c = f24_8_key(a) > f24_8_key(b);

endmodule

// File: rtl/full_argmax.sv
// Argmax classifier over one frame of NUM_CLASSES float_24_8 beats, checked against a label.
// Optional record counters (frames_total/frames_ok) are enabled by FULL_ARGMAX_STATS_EN.
module full_argmax
  import full_argmax_pkg::*;
#(
  parameter int unsigned NUM_CLASSES = 6,
  parameter int unsigned IDX_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      st_data_out,
  input  logic             st_data_out_vld,
  input  logic             st_data_out_fst,
  output logic             st_data_out_rdy,
  input  logic [IDX_W-1:0] label,
  input  logic             label_vld,
  output logic             label_rdy,
  output logic [IDX_W-1:0] class_out,
  output logic [31:0]      class_max,
  output logic             class_ok,
  output logic             class_vld,
  input  logic             class_rdy,
  output logic             frame_abort
`ifdef FULL_ARGMAX_STATS_EN
  ,
  output logic [31:0]      frames_total,
  output logic [31:0]      frames_ok
`endif
);

  if (NUM_CLASSES < 2 || NUM_CLASSES > 255 || NUM_CLASSES > (1 << IDX_W)) begin : g_bad_cfg
    $fatal(1, "full_argmax: NUM_CLASSES must be 2..255 and fit in IDX_W bits");
  end

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  full_argmax_state_t state, state_d;
  logic [31:0]        best_val, best_val_d;
  logic [IDX_W-1:0]   best_idx, best_idx_d;
  logic [IDX_W-1:0]   beat_cnt, beat_cnt_d;
  logic               label_held, label_held_d;
  logic [IDX_W-1:0]   label_q, label_q_d;
  logic [IDX_W-1:0]   class_out_d;
  logic [31:0]        class_max_d;
  logic               class_ok_d;
  logic               class_vld_d;
  logic               frame_abort_d;
  logic               st_rdy_d;
  logic               label_rdy_d;
  logic               beat_acc_c;
  logic               beat_gt_c;

  assign beat_acc_c = st_data_out_vld & st_data_out_rdy;

  f24_8_gt u_gt (
    .a        (st_data_out),
    .b        (best_val),
    .a_gt_b_c (beat_gt_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      best_val        <= '0;
      best_idx        <= '0;
      beat_cnt        <= '0;
      label_held      <= 1'b0;
      label_q         <= '0;
      class_out       <= '0;
      class_max       <= '0;
      class_ok        <= 1'b0;
      class_vld       <= 1'b0;
      frame_abort     <= 1'b0;
      st_data_out_rdy <= 1'b1;
      label_rdy       <= 1'b1;
    end else begin
      state           <= state_d;
      best_val        <= best_val_d;
      best_idx        <= best_idx_d;
      beat_cnt        <= beat_cnt_d;
      label_held      <= label_held_d;
      label_q         <= label_q_d;
      class_out       <= class_out_d;
      class_max       <= class_max_d;
      class_ok        <= class_ok_d;
      class_vld       <= class_vld_d;
      frame_abort     <= frame_abort_d;
      st_data_out_rdy <= st_rdy_d;
      label_rdy       <= label_rdy_d;
    end
  end

  always_comb begin
    state_d       = state;
    best_val_d    = best_val;
    best_idx_d    = best_idx;
    beat_cnt_d    = beat_cnt;
    label_held_d  = label_held;
    label_q_d     = label_q;
    class_out_d   = class_out;
    class_max_d   = class_max;
    class_ok_d    = class_ok;
    frame_abort_d = 1'b0;

    unique case (state)
      IDLE: begin
        if (beat_acc_c && st_data_out_fst) begin
          best_val_d = st_data_out;
          best_idx_d = '0;
          beat_cnt_d = IDX_W'(1);
          state_d    = ACCUM;
        end
      end
      ACCUM: begin
        if (beat_acc_c) begin
          if (st_data_out_fst) begin
            best_val_d    = st_data_out;
            best_idx_d    = '0;
            beat_cnt_d    = IDX_W'(1);
            frame_abort_d = 1'b1;
          end else begin
            // Strict compare keeps the lowest index on ties.
            if (beat_gt_c) begin
              best_val_d = st_data_out;
              best_idx_d = beat_cnt;
            end
            if (beat_cnt == LAST_IDX) begin
              state_d = RESULT;
            end else begin
              beat_cnt_d = beat_cnt + IDX_W'(1);
            end
          end
        end
      end
      RESULT: begin
        if (class_vld && class_rdy) begin
          state_d      = IDLE;
          label_held_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (label_vld && label_rdy) begin
      label_held_d = 1'b1;
      label_q_d    = label;
    end

    // Record fields track the final best; they only move while no record is pending.
    if (state_d == RESULT) begin
      class_out_d = best_idx_d;
      class_max_d = best_val_d;
      class_ok_d  = (best_idx_d == label_q_d);
    end
  end

  assign class_vld_d = (state_d == RESULT) && label_held_d;
  assign st_rdy_d    = (state_d != RESULT);
  assign label_rdy_d = !label_held_d;

`ifdef FULL_ARGMAX_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      frames_total <= '0;
      frames_ok    <= '0;
    end else if (class_vld && class_rdy) begin
      frames_total <= frames_total + 32'd1;
      if (class_ok) begin
        frames_ok <= frames_ok + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_full_argmax.sv
// Scoreboard bench for full_argmax: directed frames, expected records queued at stimulus time.
module tb_full_argmax;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] st_data_out;
  logic        st_data_out_vld;
  logic        st_data_out_fst;
  logic        st_data_out_rdy;
  logic [7:0]  label;
  logic        label_vld;
  logic        label_rdy;
  logic [7:0]  class_out;
  logic [31:0] class_max;
  logic        class_ok;
  logic        class_vld;
  logic        class_rdy;
  logic        frame_abort;
`ifdef FULL_ARGMAX_STATS_EN
  logic [31:0] frames_total;
  logic [31:0] frames_ok;
`endif

  always #5 clk = ~clk;

  full_argmax #(.NUM_CLASSES(6), .IDX_W(8)) dut (
    .clk             (clk),
    .reset           (reset),
    .st_data_out     (st_data_out),
    .st_data_out_vld (st_data_out_vld),
    .st_data_out_fst (st_data_out_fst),
    .st_data_out_rdy (st_data_out_rdy),
    .label           (label),
    .label_vld       (label_vld),
    .label_rdy       (label_rdy),
    .class_out       (class_out),
    .class_max       (class_max),
    .class_ok        (class_ok),
    .class_vld       (class_vld),
    .class_rdy       (class_rdy),
    .frame_abort     (frame_abort)
`ifdef FULL_ARGMAX_STATS_EN
    ,
    .frames_total    (frames_total),
    .frames_ok       (frames_ok)
`endif
  );

  typedef struct packed {
    logic [7:0]  idx;
    logic [31:0] val;
    logic        ok;
  } rec_t;

  rec_t        sb[$];
  rec_t        prev;
  logic        have_prev = 1'b0;
  int          n_total = 0;
  int          n_bad = 0;
  int          abort_cnt = 0;
  logic [31:0] fv [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int idx, input logic [31:0] val, input logic ok);
    rec_t r;
    r.idx = 8'(idx);
    r.val = val;
    r.ok  = ok;
    sb.push_back(r);
  endtask

  task automatic send_beat(input logic [31:0] d, input logic f);
    logic acc;
    acc = 1'b0;
    st_data_out     = d;
    st_data_out_fst = f;
    st_data_out_vld = 1'b1;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = st_data_out_rdy;
      tick();
    end
    if (!acc) chk("beat_accept_timeout", 32'(acc), 32'd1);
    st_data_out_vld = 1'b0;
    st_data_out_fst = 1'b0;
  endtask

  task automatic send_label(input logic [7:0] l);
    logic acc;
    acc = 1'b0;
    label     = l;
    label_vld = 1'b1;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = label_rdy;
      tick();
    end
    if (!acc) chk("label_accept_timeout", 32'(acc), 32'd1);
    label_vld = 1'b0;
  endtask

  task automatic send_frame();
    for (int i = 0; i < 6; i++) send_beat(fv[i], i == 0);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) tick();
    if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: pop on every record handshake, and require a stalled record to stay put.
  always @(negedge clk) begin
    rec_t e;
    if (frame_abort) abort_cnt++;
    if (reset) begin
      have_prev = 1'b0;
    end else if (class_vld) begin
      if (have_prev) begin
        chk("stall_class_out", 32'(class_out), 32'(prev.idx));
        chk("stall_class_max", class_max, prev.val);
        chk("stall_class_ok", 32'(class_ok), 32'(prev.ok));
      end
      if (class_rdy) begin
        if (sb.size() == 0) begin
          chk("unexpected_record", 32'(class_out), 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          chk("class_out", 32'(class_out), 32'(e.idx));
          chk("class_max", class_max, e.val);
          chk("class_ok", 32'(class_ok), 32'(e.ok));
        end
        have_prev = 1'b0;
      end else begin
        have_prev = 1'b1;
        prev.idx  = class_out;
        prev.val  = class_max;
        prev.ok   = class_ok;
      end
    end else begin
      have_prev = 1'b0;
    end
  end

  task automatic check_reset_values(input string tag);
    chk({tag, "_st_rdy"}, 32'(st_data_out_rdy), 32'd1);
    chk({tag, "_label_rdy"}, 32'(label_rdy), 32'd1);
    chk({tag, "_class_vld"}, 32'(class_vld), 32'd0);
    chk({tag, "_class_ok"}, 32'(class_ok), 32'd0);
    chk({tag, "_class_out"}, 32'(class_out), 32'd0);
    chk({tag, "_class_max"}, class_max, 32'd0);
    chk({tag, "_frame_abort"}, 32'(frame_abort), 32'd0);
  endtask

  initial begin
    int ab0;
    reset = 1'b1;
    st_data_out = '0;
    st_data_out_vld = 1'b0;
    st_data_out_fst = 1'b0;
    label = '0;
    label_vld = 1'b0;
    class_rdy = 1'b1;
    tick();
    tick();
    @(negedge clk);
    check_reset_values("rst");
    tick();
    reset = 1'b0;
    tick();

    // 1: max 3.0 at index 1, label 1; label already held so record follows last beat.
    send_label(8'd1);
    fv = '{32'h3F800000, 32'h40400000, 32'h40000000, 32'hC0800000, 32'h3F000000, 32'h00000000};
    push(1, 32'h40400000, 1'b1);
    send_frame();
    @(negedge clk);
    chk("t1_latency_vld", 32'(class_vld), 32'd1);
    wait_drain();

    // 2: tie at 5.0 keeps the lower index.
    send_label(8'd2);
    fv = '{32'h40000000, 32'h40A00000, 32'h40A00000, 32'h3F800000, 32'h00000000, 32'h3F000000};
    push(1, 32'h40A00000, 1'b0);
    send_frame();
    wait_drain();

    // 3: all-negative frame, label withheld for 10 cycles.
    fv = '{32'hBF800000, 32'hBF000000, 32'hC0000000, 32'hBE800000, 32'hC0400000, 32'hC1000000};
    push(3, 32'hBE800000, 1'b1);
    send_frame();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t3_st_rdy_low", 32'(st_data_out_rdy), 32'd0);
      chk("t3_vld_low", 32'(class_vld), 32'd0);
      tick();
    end
    send_label(8'd3);
    @(negedge clk);
    chk("t3_vld_after_label", 32'(class_vld), 32'd1);
    wait_drain();

    // 4: partial frame of large values, restarted by fst on beat 3.
    ab0 = abort_cnt;
    send_label(8'd2);
    send_beat(32'h42C80000, 1'b1);
    send_beat(32'h42C80000, 1'b0);
    send_beat(32'h42C80000, 1'b0);
    fv = '{32'h3F000000, 32'h3F800000, 32'h40E00000, 32'h40000000, 32'h40E00000, 32'hBF800000};
    push(2, 32'h40E00000, 1'b1);
    send_frame();
    wait_drain();
    chk("t4_abort_pulses", 32'(abort_cnt - ab0), 32'd1);

    // 5: downstream stall with a beat offered, then -0/+0 frame, then reset mid-frame.
    class_rdy = 1'b0;
    send_label(8'd0);
    fv = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h3F800000};
    push(5, 32'h3F800000, 1'b0);
    send_frame();
    st_data_out = 32'h42C80000;
    st_data_out_fst = 1'b1;
    st_data_out_vld = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5_stall_vld", 32'(class_vld), 32'd1);
      chk("t5_stall_st_rdy", 32'(st_data_out_rdy), 32'd0);
      tick();
    end
    st_data_out_vld = 1'b0;
    st_data_out_fst = 1'b0;
    class_rdy = 1'b1;
    wait_drain();

    send_label(8'd0);
    fv = '{32'h80000000, 32'h00000000, 32'h80000000, 32'h00000000, 32'h00000000, 32'h80000000};
    push(0, 32'h80000000, 1'b1);
    send_frame();
    wait_drain();

    send_label(8'd3);
    send_beat(32'h3F800000, 1'b1);
    send_beat(32'h40000000, 1'b0);
    reset = 1'b1;
    tick();
    @(negedge clk);
    check_reset_values("midrst");
    tick();
    reset = 1'b0;
    tick();

    // 6: eight frames, first five labelled correctly.
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 6; i++) fv[i] = (i == k % 6) ? 32'h41200000 : 32'h3F800000;
      send_label((k < 5) ? 8'(k % 6) : 8'((k % 6 + 1) % 6));
      push(k % 6, 32'h41200000, k < 5);
      send_frame();
    end
    wait_drain();
    tick();
`ifdef FULL_ARGMAX_STATS_EN
    @(negedge clk);
    chk("frames_total", frames_total, 32'd8);
    chk("frames_ok", frames_ok, 32'd5);
`endif
    tick();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
